// File: rtl/key_input_scheduler.sv
// Debounces the four Tetris buttons, adds delayed auto-repeat, and hands single
// actions to the game FSM one at a time over a valid/ready handshake.
module key_input_scheduler #(
    parameter int unsigned     NKEYS           = 4,
    parameter int unsigned     DEBOUNCE_CYCLES = 500000,
    parameter int unsigned     DAS_DELAY       = 8000000,
    parameter int unsigned     DAS_RATE        = 2500000,
    parameter logic [NKEYS-1:0] REPEAT_MASK    = 4'b1110
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NKEYS-1:0] key_sync,
    input  logic             action_ready,
    output logic             action_valid,
    output logic [1:0]       action_code,
    output logic [NKEYS-1:0] key_level
);

    localparam int unsigned DW     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned RW_DLY = $clog2(DAS_DELAY) + 1;
    localparam int unsigned RW_RPT = $clog2(DAS_RATE) + 1;
    localparam int unsigned RW     = (RW_DLY > RW_RPT) ? RW_DLY : RW_RPT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    logic [NKEYS-1:0] pend;
    logic [NKEYS-1:0] pend_set_c;
    logic [1:0]       winner_c;
    logic [NKEYS-1:0] winner_mask_c;

    for (genvar k = 0; k < NKEYS; k++) begin : g_key
        localparam bit REP = REPEAT_MASK[k];

        logic          lvl;
        logic [DW-1:0] cnt_d;
        logic [RW-1:0] cnt_r;
        key_state_t    state;

        // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_ff @(posedge clock) begin
            if (reset) begin
                lvl   <= 1'b0;
                cnt_d <= '0;
            end else if (key_sync[k] != lvl) begin
                if (cnt_d == DW'(DEBOUNCE_CYCLES - 1)) begin
                    lvl   <= ~lvl;
                    cnt_d <= '0;
                end else begin
                    cnt_d <= cnt_d + DW'(1);
                end
            end else begin
                cnt_d <= '0;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state <= IDLE;
                cnt_r <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (lvl) begin
                            cnt_r <= '0;
                            state <= DELAY;
                        end
                    end
                    DELAY: begin
                        if (!lvl) begin
                            state <= IDLE;
                        end else if (REP) begin
                            if (cnt_r == RW'(DAS_DELAY - 1)) begin
                                cnt_r <= '0;
                                state <= REPEAT;
                            end else begin
                                cnt_r <= cnt_r + RW'(1);
                            end
                        end
                    end
                    REPEAT: begin
                        if (!lvl) begin
                            state <= IDLE;
                        end else if (cnt_r == RW'(DAS_RATE - 1)) begin
                            cnt_r <= '0;
                        end else begin
                            cnt_r <= cnt_r + RW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        // Action events: the press itself, the first repeat, and each later repeat
        assign pend_set_c[k] = lvl && (
                                   (state == IDLE) ||
                                   (state == DELAY && REP && cnt_r == RW'(DAS_DELAY - 1)) ||
                                   (state == REPEAT && cnt_r == RW'(DAS_RATE - 1)));
        assign key_level[k] = lvl;
    end

    // Lowest pending index wins
    always_comb begin
        winner_c      = '0;
        winner_mask_c = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                winner_c      = 2'(i);
                winner_mask_c = NKEYS'(1) << i;
            end
        end
    end

    // New events are OR-ed in after the load clear so a same-edge set survives
    always_ff @(posedge clock) begin
        if (reset) begin
            pend         <= '0;
            action_valid <= 1'b0;
            action_code  <= '0;
        end else if ((!action_valid || action_ready) && (|pend)) begin
            action_valid <= 1'b1;
            action_code  <= winner_c;
            pend         <= (pend & ~winner_mask_c) | pend_set_c;
        end else begin
            if (action_ready) begin
                action_valid <= 1'b0;
            end
            pend <= pend | pend_set_c;
        end
    end

endmodule

// File: doc/key_input_scheduler.md
# key_input_scheduler

Converts the four synchronized Tetris button levels (rotate, left, right, drop) into single game actions, delivered one at a time over a valid/ready handshake. Each key is debounced and edge-detected. Left, right and drop get delayed auto-repeat; rotate fires once per press. Sits between the per-key two-flop synchronizers and the game-logic FSM, in the 50 MHz domain.

## Interface
- NKEYS, 4: number of keys. Index 0 = rotate, 1 = left, 2 = right, 3 = drop.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to change a debounced level. Minimum 1.
- DAS_DELAY, 8000000: cycles from accepted press to first auto-repeat. Minimum 1.
- DAS_RATE, 2500000: cycles between later repeats. Minimum 1.
- REPEAT_MASK, 4'b1110: bit k = 1 enables auto-repeat for key k.

- clock  in  1  system clock, 50 MHz; all state updates on its rising edge
- reset  in  1  synchronous, active-high; one clock; clears all state
- key_sync  in  NKEYS  synchronized key levels, 1 = pressed
- action_ready  in  1  game FSM accepts the presented action this cycle
- action_valid  out  1  action_code holds a pending action
- action_code  out  2  index of the key whose action is presented
- key_level  out  NKEYS  debounced key levels, for display/debug

## Operation
- **Reset values:** action_valid=0, action_code=0, key_level=0, all counters 0, all key FSMs IDLE, all pending bits 0.
- **Debounce (per key):**
  - Counter cnt_d increments while key_sync[k] != key_level[k].
  - It clears to 0 whenever they are equal.
  - When cnt_d reaches DEBOUNCE_CYCLES-1 while still different, key_level[k] toggles at that edge and cnt_d clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- **Key FSM (per key), states IDLE, DELAY, REPEAT:**
  - IDLE: on key_level[k]=1, set pend[k], clear cnt_r, go DELAY.
  - DELAY:
    - If key_level[k]=0, go IDLE.
    - Otherwise, if REPEAT_MASK[k]=1, increment cnt_r. When cnt_r = DAS_DELAY-1, set pend[k], clear cnt_r, go REPEAT.
    - If REPEAT_MASK[k]=0, stay in DELAY with no counting until release.
  - REPEAT:
    - If key_level[k]=0, go IDLE.
    - Otherwise increment cnt_r. When cnt_r = DAS_RATE-1, set pend[k] and clear cnt_r.
  - Release never clears pend[k]; an accepted press is never lost.
  - Setting pend[k] while it is already 1 merges into one action; there is no counting beyond 1.
- **Arbitration and output:**
  - Fixed priority, lowest index first (rotate > left > right > drop).
  - When action_valid=0 and any pend bit is set: at the next edge, action_valid=1, action_code = index of the winner, and the winner's pend bit is cleared.
  - action_valid and action_code hold unchanged until a cycle with action_ready=1.
  - On a handshake edge:
    - If other pend bits are set, load the next winner with action_valid staying 1 (back-to-back, no bubble).
    - Otherwise action_valid=0.
  - A pend set and a pend clear for the same key on the same edge: the set wins. This is the case where the key is loaded to the output while a new repeat event arrives, so the bit stays 1.
- **Counter widths:** $clog2 of each parameter plus 1. No wrap-around is reachable, because every counter clears at its terminal value.

## Timing
- **Press latency:**
  - key_sync[k] rises and is first sampled high at edge E.
  - key_level[k]=1 at edge E+DEBOUNCE_CYCLES-1.
  - pend[k]=1 one edge later.
  - action_valid=1 at edge E+DEBOUNCE_CYCLES+1, if the output was idle.
- **Repeat timing:**
  - First repeat pend is set DAS_DELAY edges after the press pend.
  - Later repeats follow every DAS_RATE edges.
- **Throughput:** one action per cycle when action_ready is held high.
- **Mid-operation reset:** reset asserted on any edge returns everything to reset values at that edge and drops any presented or pending action. If key_sync is still high afterwards, a fresh debounce period must pass before a new action appears.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, DAS_DELAY=10, DAS_RATE=3.

1. **Single rotate press:** key_sync=0001 held 30 cycles, action_ready=1 → exactly one action, code 0. action_valid first high 5 edges after the first sampled high. No repeats.
2. **Bounce rejection:** key_sync[1] toggles high 3 cycles / low 1 cycle ×5 → key_level stays 0 and no action.
3. **Auto-repeat on left:** key_sync=0010 held 40 cycles, action_ready=1 → code-1 actions at relative edges 0, 10, 13, 16, …. The repeats stop after release plus 4 cycles of debounce.
4. **Priority and backpressure:**
   - Stimulus: right and rotate are pressed on the same cycle; action_ready=0 for 20 cycles, then 1.
   - Response: code 0 is held stable through the stall, then code 2 on the very next edge. The right repeats that occurred during the stall merge into a single pending action.
5. **Press not lost:** drop pressed 6 cycles then released while action_ready=0 → one code-3 action is still delivered once ready rises.
6. **Reset mid-repeat:** reset pulsed 1 cycle during left auto-repeat, with action_valid=1 → the next edge shows all outputs 0. The next action (code 1) arrives 5 edges after reset deasserts, with the key still held.
